fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 98 +++++++++
 tb/tb_fetch_unit.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: issues instruction memory reads from the PC stage and buffers
// the returning words in a 2-entry FIFO of {pc, instr} for the decoder.
// Optional macro FETCH_HALT_EN: an all-ones instruction pushed into the
// queue halts fetching until the next flush or reset.
module fetch_unit #(
  parameter int IMM_S   = 4,
  parameter int INSTR_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [IMM_S-1:0]   pc_in,
  input  logic               pc_valid,
  output logic               pc_stall,
  input  logic               flush,
  output logic               mem_en,
  output logic [IMM_S-1:0]   mem_addr,
  input  logic [INSTR_W-1:0] mem_rdata,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr,
  output logic [IMM_S-1:0]   instr_pc
);

  logic [1:0]         count;
  logic               req_v;
  logic [IMM_S-1:0]   req_pc;
  logic [IMM_S-1:0]   q_pc    [2];
  logic [INSTR_W-1:0] q_instr [2];

  logic       pop;
  logic       push;
  logic       issue;
  logic [1:0] occ;
  logic       wr_idx;

`ifdef FETCH_HALT_EN
  logic halted;
`endif

  // Issue/stall decision and queue head presentation.
  // The stall test counts a same-cycle pop as freeing a slot, which is what
  // lets back-to-back fetches sustain one instruction per cycle.
  always_comb begin
    pop         = (count != 2'd0) && instr_ready;
    push        = req_v;
    occ         = count + {1'b0, req_v} - {1'b0, pop};
    pc_stall    = flush || (occ >= 2'd2);
`ifdef FETCH_HALT_EN
    if (halted) pc_stall = 1'b1;
`endif
    issue       = reset && pc_valid && !pc_stall;
    mem_en      = issue;
    mem_addr    = pc_in;
    wr_idx      = (count == 2'd1) && !pop;
    instr_valid = (count != 2'd0);
    instr       = q_instr[0];
    instr_pc    = q_pc[0];
  end

  // In-flight request tracking, FIFO storage and occupancy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count  <= '0;
      req_v  <= 1'b0;
      req_pc <= '0;
      for (int unsigned i = 0; i < 2; i++) begin
        q_pc[i]    <= '0;
        q_instr[i] <= '0;
      end
`ifdef FETCH_HALT_EN
      halted <= 1'b0;
`endif
    end else if (flush) begin
      count  <= '0;
      req_v  <= 1'b0;
`ifdef FETCH_HALT_EN
      halted <= 1'b0;
`endif
    end else begin
      req_v <= issue;
      if (issue) req_pc <= pc_in;
      if (pop) begin
        q_pc[0]    <= q_pc[1];
        q_instr[0] <= q_instr[1];
      end
      // A push into slot 0 during a pop overrides the shift above.
      if (push) begin
        q_pc[wr_idx]    <= req_pc;
        q_instr[wr_idx] <= mem_rdata;
      end
      count <= count + {1'b0, push} - {1'b0, pop};
`ifdef FETCH_HALT_EN
      if (push && (&mem_rdata)) halted <= 1'b1;
`endif
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a queue-based model of the fetch
// pipeline is compared with the DUT every cycle, with directed scenarios
// pinned by literal expectations followed by randomized traffic.
module tb_fetch_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] pc_in;
  logic       pc_valid;
  logic       pc_stall;
  logic       flush;
  logic       mem_en;
  logic [3:0] mem_addr;
  logic [7:0] mem_rdata;
  logic       instr_valid;
  logic       instr_ready;
  logic [7:0] instr;
  logic [3:0] instr_pc;

  int checks   = 0;
  int failures = 0;

  logic [7:0]  mem [16];
  logic [11:0] mq [$];
  bit          pend;
  logic [3:0]  pend_pc;
  bit          halted_m;

  logic       obs_valid, obs_stall, obs_en;
  logic [7:0] obs_instr;
  logic [3:0] obs_pc;

  fetch_unit #(.IMM_S(4), .INSTR_W(8)) dut (
    .clk(clk), .reset(reset), .pc_in(pc_in), .pc_valid(pc_valid),
    .pc_stall(pc_stall), .flush(flush), .mem_en(mem_en), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .instr_pc(instr_pc)
  );

  always #5 clk = ~clk;

  // Instruction memory: one-cycle read latency, junk when not enabled.
  always @(posedge clk) begin
    if (mem_en) mem_rdata <= mem[mem_addr];
    else        mem_rdata <= 8'($urandom);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    pend     = 0;
    halted_m = 0;
  endtask

  // One clock cycle: drive inputs, compare outputs with the model, then
  // advance the model by what the coming edge must do.
  task automatic step(input logic pv, input logic [3:0] pci, input logic fl, input logic rdy);
    bit e_valid, e_pop, e_stall, e_en;
    int occ;
    logic [7:0] d;
    @(negedge clk);
    pc_valid = pv; pc_in = pci; flush = fl; instr_ready = rdy;
    #1;
    e_valid = (mq.size() != 0);
    e_pop   = e_valid && rdy;
    occ     = mq.size() + int'(pend) - int'(e_pop);
    e_stall = fl || halted_m || (occ >= 2);
    e_en    = pv && !e_stall;
    chk("instr_valid", instr_valid, e_valid);
    chk("pc_stall", pc_stall, e_stall);
    chk("mem_en", mem_en, e_en);
    chk("mem_addr", mem_addr, pci);
    if (e_valid) begin
      chk("instr", instr, mq[0][7:0]);
      chk("instr_pc", instr_pc, mq[0][11:8]);
    end
    obs_valid = instr_valid; obs_stall = pc_stall; obs_en = mem_en;
    obs_instr = instr; obs_pc = instr_pc;
    if (fl) begin
      model_clear();
    end else begin
      if (e_pop) void'(mq.pop_front());
      if (pend) begin
        d = mem[pend_pc];
        mq.push_back({pend_pc, d});
`ifdef FETCH_HALT_EN
        if (d == 8'hFF) halted_m = 1;
`endif
      end
      pend    = e_en;
      pend_pc = pci;
    end
  endtask

  // Reset asserted mid-cycle: outputs must clear without waiting for an edge.
  task automatic areset();
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("rst_instr_valid", instr_valid, 1'b0);
    chk("rst_instr", instr, 8'h00);
    chk("rst_instr_pc", instr_pc, 4'h0);
    chk("rst_mem_en", mem_en, 1'b0);
    model_clear();
    pc_valid = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    reset = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'(8'h10 + i);
    reset = 1'b0; pc_valid = 1'b1; pc_in = 4'h0; flush = 1'b0; instr_ready = 1'b0;
    model_clear();
    #2;
    chk("init_instr_valid", instr_valid, 1'b0);
    chk("init_instr", instr, 8'h00);
    chk("init_instr_pc", instr_pc, 4'h0);
    chk("init_mem_en", mem_en, 1'b0);
    pc_valid = 1'b0;
    @(negedge clk);
    #2;
    reset = 1'b1;

    // Streaming fetch of addresses 0..3.
    step(1, 0, 0, 1); chk("s29_issue0", obs_en, 1'b1);
    step(1, 1, 0, 1); chk("s29_lat", obs_valid, 1'b0);
    step(1, 2, 0, 1); chk("s29_i0", {obs_valid, obs_pc, obs_instr}, {1'b1, 4'd0, 8'h10});
    step(1, 3, 0, 1); chk("s29_i1", {obs_valid, obs_pc, obs_instr}, {1'b1, 4'd1, 8'h11});
    step(0, 0, 0, 1); chk("s29_i2", {obs_valid, obs_pc, obs_instr}, {1'b1, 4'd2, 8'h12});
    step(0, 0, 0, 1); chk("s29_i3", {obs_valid, obs_pc, obs_instr}, {1'b1, 4'd3, 8'h13});
    step(0, 0, 0, 1); chk("s29_empty", obs_valid, 1'b0);

    // Backpressure: queue fills to two, then one pop releases the stall.
    step(1, 4, 0, 0);
    step(1, 5, 0, 0);
    step(1, 6, 0, 0); chk("s30_stall_a", {obs_stall, obs_en}, 2'b10);
    step(1, 6, 0, 0); chk("s30_full", {obs_stall, obs_en, obs_valid, obs_pc}, {3'b101, 4'd4});
    step(1, 6, 0, 1); chk("s30_pop", {obs_stall, obs_en, obs_pc}, {2'b01, 4'd4});
    step(1, 7, 0, 0); chk("s30_order", obs_pc, 4'd5);
    repeat (4) step(0, 0, 0, 1);

    // Flush with queued data and an in-flight fetch of pc 5.
    step(1, 3, 0, 0);
    step(1, 4, 0, 0);
    step(1, 5, 0, 0);
    step(1, 5, 0, 0);
    step(1, 5, 0, 1); chk("s31_issue5", obs_en, 1'b1);
    step(0, 0, 1, 0); chk("s31_flush_stall", obs_stall, 1'b1);
    step(1, 9, 0, 1); chk("s31_after", {obs_valid, obs_stall, obs_en}, 3'b001);
    step(0, 0, 0, 1); chk("s31_lat", obs_valid, 1'b0);
    step(0, 0, 0, 1); chk("s31_pc9", {obs_valid, obs_pc, obs_instr}, {1'b1, 4'd9, 8'h19});
    step(0, 0, 0, 1); chk("s31_no5", obs_valid, 1'b0);

    // Flush and pop together with a full queue.
    step(1, 1, 0, 0);
    step(1, 2, 0, 0);
    step(1, 3, 0, 0);
    step(0, 0, 1, 1); chk("s32_full", obs_valid, 1'b1);
    step(0, 0, 0, 1); chk("s32_empty", obs_valid, 1'b0);
    step(0, 0, 0, 1); chk("s32_stay", obs_valid, 1'b0);

    // Asynchronous reset mid-stream.
    step(1, 1, 0, 0);
    step(1, 2, 0, 0);
    areset();
    step(1, 7, 0, 1);
    step(1, 8, 0, 1); chk("s33_lat", obs_valid, 1'b0);
    step(0, 0, 0, 1); chk("s33_first", {obs_valid, obs_pc, obs_instr}, {1'b1, 4'd7, 8'h17});
    repeat (3) step(0, 0, 0, 1);

    // All-ones instruction at address 2.
    mem[2] = 8'hFF;
    step(1, 0, 0, 1);
    step(1, 1, 0, 1);
    step(1, 2, 0, 1);
    step(1, 3, 0, 1);
    step(1, 4, 0, 1); chk("s34_ff", {obs_valid, obs_pc, obs_instr}, {1'b1, 4'd2, 8'hFF});
`ifdef FETCH_HALT_EN
    chk("s34_halt", {obs_stall, obs_en}, 2'b10);
    step(1, 4, 0, 1); chk("s34_hold_a", {obs_stall, obs_en}, 2'b10);
    step(1, 4, 0, 1); chk("s34_hold_b", {obs_stall, obs_en, obs_valid}, 3'b100);
    step(0, 0, 1, 1);
    step(1, 5, 0, 1); chk("s34_resume", {obs_stall, obs_en}, 2'b01);
`else
    chk("s34_cont", {obs_stall, obs_en}, 2'b01);
    step(1, 5, 0, 1); chk("s34_pc3", {obs_pc, obs_instr}, {4'd3, 8'h13});
`endif
    repeat (4) step(0, 0, 0, 1);
    mem[2] = 8'h12;

    // Randomized traffic with occasional flushes and resets.
    for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
    for (int n = 0; n < 1500; n++) begin
      if (n % 500 == 250) areset();
      step(($urandom_range(0, 9) < 8), 4'($urandom), ($urandom_range(0, 19) == 0),
           ($urandom_range(0, 9) < 7));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
